// File: rtl/adder_pkg.sv
// Shared constants and FSM encoding for the adder-result to BCD converter.
package adder_pkg;
  localparam int IN_W      = 9;
  localparam int BCD_W     = 12;
  localparam int SHIFT_CNT = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] iDigit,
  output logic [3:0] oDigit
);
  assign oDigit = (iDigit >= 4'd5) ? iDigit + 4'd3 : iDigit;
endmodule

// File: rtl/adder_bcd_conv.sv
// Sequential shift-add-3 converter turning a 9-bit adder result
// (unsigned or sign-magnitude) into three packed BCD digits.
module adder_bcd_conv #(
  parameter int IN_W  = adder_pkg::IN_W,
  parameter int BCD_W = adder_pkg::BCD_W
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic             iSA,
  input  logic [IN_W-1:0]  iData,
  input  logic             iData_C,
  output logic             oBusy,
  output logic             oDone,
  output logic             oSign,
  output logic [BCD_W-1:0] oBcd,
  output logic             oOvf
);
  import adder_pkg::*;

  localparam int NUM_DIGITS = BCD_W / 4;
  localparam int CNT_W      = $clog2(SHIFT_CNT + 1);

  state_t            state, stateNext;
  logic [CNT_W-1:0]  cnt;
  logic [IN_W-1:0]   mag;
  logic [BCD_W-1:0]  bcd, bcdAdj;
  logic              sign, ovf;
  logic              lastShift;

  assign lastShift = (cnt == CNT_W'(SHIFT_CNT - 1));

  genvar d;
  generate
    for (d = 0; d < NUM_DIGITS; d++) begin : gDigit
      bcd_digit_adj uAdj (
        .iDigit(bcd[d*4 +: 4]),
        .oDigit(bcdAdj[d*4 +: 4])
      );
    end
  endgenerate

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (iStart)    stateNext = SHIFT;
      SHIFT:   if (lastShift) stateNext = DONE;
      DONE:                   stateNext = IDLE;
      default:                stateNext = IDLE;
    endcase
  end

  always_comb begin
    oBusy = (state == SHIFT) || (state == DONE);
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cnt   <= '0;
      mag   <= '0;
      bcd   <= '0;
      sign  <= 1'b0;
      ovf   <= 1'b0;
      oDone <= 1'b0;
      oSign <= 1'b0;
      oBcd  <= '0;
      oOvf  <= 1'b0;
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE: if (iStart) begin
          cnt <= '0;
          bcd <= '0;
          ovf <= iData_C;
          // Sign-magnitude drops the sign bit; a zero magnitude is never negative.
          if (iSA) begin
            mag  <= {1'b0, iData[IN_W-2:0]};
            sign <= iData[IN_W-1] & (|iData[IN_W-2:0]);
          end else begin
            mag  <= iData;
            sign <= 1'b0;
          end
        end
        SHIFT: begin
          bcd <= {bcdAdj[BCD_W-2:0], mag[IN_W-1]};
          mag <= {mag[IN_W-2:0], 1'b0};
          cnt <= cnt + 1'b1;
        end
        DONE: begin
          oBcd  <= bcd;
          oSign <= sign;
          oOvf  <= ovf;
          oDone <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_bcd_conv.sv
// Randomized self-checking bench for adder_bcd_conv against an arithmetic model.
module tb_adder_bcd_conv;
  logic        iClk = 1'b0;
  logic        iRst_n;
  logic        iStart, iSA, iData_C;
  logic [8:0]  iData;
  logic        oBusy, oDone, oSign, oOvf;
  logic [11:0] oBcd;

  int nChecks = 0;
  int nErrors = 0;
  logic [11:0] prevBcd;
  logic        prevSign, prevOvf;

  always #5 iClk = ~iClk;

  adder_bcd_conv dut (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iSA(iSA),
    .iData(iData), .iData_C(iData_C), .oBusy(oBusy), .oDone(oDone),
    .oSign(oSign), .oBcd(oBcd), .oOvf(oOvf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] model(input logic sa, input logic [8:0] data);
    int m;
    logic s;
    m = sa ? int'(data[7:0]) : int'(data);
    s = sa && data[8] && (m != 0);
    return {s, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  // Drives one request, scrambles inputs while busy, checks timing and result.
  task automatic runConv(input logic sa, input logic [8:0] data, input logic c);
    logic [12:0] exp;
    exp = model(sa, data);
    iSA = sa; iData = data; iData_C = c; iStart = 1'b1;
    @(posedge iClk); #1;
    for (int k = 1; k <= 10; k++) begin
      if (k < 10) begin
        chk("busy", oBusy, 1'b1);
        chk("doneEarly", oDone, 1'b0);
        chk("holdBcd", oBcd, prevBcd);
        chk("holdSign", oSign, prevSign);
        chk("holdOvf", oOvf, prevOvf);
        iStart = 1'($urandom); iSA = 1'($urandom);
        iData = 9'($urandom); iData_C = 1'($urandom);
      end else begin
        iStart = 1'b0;
      end
      @(posedge iClk); #1;
    end
    chk("done", oDone, 1'b1);
    chk("busyAtDone", oBusy, 1'b0);
    chk("bcd", oBcd, exp[11:0]);
    chk("sign", oSign, exp[12]);
    chk("ovf", oOvf, c);
    prevBcd = exp[11:0]; prevSign = exp[12]; prevOvf = c;
    @(posedge iClk); #1;
    chk("donePulse", oDone, 1'b0);
    chk("idleBusy", oBusy, 1'b0);
  endtask

  initial begin
    iRst_n = 1'b0; iStart = 1'b0; iSA = 1'b0; iData = '0; iData_C = 1'b0;
    prevBcd = '0; prevSign = 1'b0; prevOvf = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    chk("rstBusy", oBusy, 1'b0);
    chk("rstDone", oDone, 1'b0);
    chk("rstBcd", oBcd, 12'h000);
    chk("rstSign", oSign, 1'b0);
    chk("rstOvf", oOvf, 1'b0);
    iRst_n = 1'b1;
    @(posedge iClk); #1;

    runConv(1'b0, 9'h1FE, 1'b1);
    chk("max510", oBcd, 12'h510);
    runConv(1'b1, 9'h105, 1'b0);
    runConv(1'b1, 9'h100, 1'b0);
    chk("negZeroSign", oSign, 1'b0);
    runConv(1'b1, 9'h0FF, 1'b1);
    runConv(1'b0, 9'h07B, 1'b0);
    chk("ignoredStart", oBcd, 12'h123);

    // Abort mid-conversion with reset.
    iSA = 1'b0; iData = 9'h077; iData_C = 1'b1; iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
    repeat (5) @(posedge iClk);
    #1;
    iRst_n = 1'b0;
    #1;
    chk("abortBusy", oBusy, 1'b0);
    chk("abortDone", oDone, 1'b0);
    chk("abortBcd", oBcd, 12'h000);
    chk("abortSign", oSign, 1'b0);
    chk("abortOvf", oOvf, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(posedge iClk); #1;
      chk("abortNoDone", oDone, 1'b0);
    end
    iRst_n = 1'b1;
    prevBcd = '0; prevSign = 1'b0; prevOvf = 1'b0;
    runConv(1'b0, 9'h02A, 1'b0);
    chk("afterRst", oBcd, 12'h042);

    for (int n = 0; n < 25; n++)
      runConv(1'($urandom), 9'($urandom), 1'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
